uart_tx_buffered: RTL

Buffered 8N1 UART transmitter and the send-side counterpart of the existing UART receive path. Accepts bytes over a valid/ready handshake into a small FIFO and serialises them LSB-first on `ser_out` at `CLKS_PER_BIT` clocks per bit, sending frames back-to-back while the FIFO holds data. It sits beside the receiver in board-level tops, for example echoing `rx_data` or streaming status bytes to the host.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_tx_buffered.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: 8N1 framing constants, default baud divisor and TX FSM states.
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 434;
  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_FRAME_BITS           = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering bytes ahead of the UART serialiser.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             push_ok;
  logic             pop_ok;

  // Full blocks pushes even if a pop happens this cycle; empty blocks pops.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a start/data/stop serialiser.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_data_valid,
  output logic                        tx_data_ready,
  output logic                        ser_out,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BIT_W  = 3;

  uart_tx_state_t            state, state_next;
  logic [BAUD_W-1:0]         baud_cnt, baud_next;
  logic [BIT_W-1:0]          bit_idx, bit_next;
  logic [UART_DATA_BITS-1:0] shift_q, shift_next;
  logic                      ser_next;
  logic                      busy_next;
  logic                      baud_last;
  logic                      push_c;
  logic                      pop_c;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_rd_data;
  logic [CNT_W-1:0]          fifo_count_next;

  assign tx_data_ready = !fifo_full;
  assign push_c        = tx_data_valid && tx_data_ready;
  assign baud_last     = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .wr_data (tx_data),
    .pop     (pop_c),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Next-state, line level and pop decision; STOP chains straight into START when data waits.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift_q;
    ser_next   = ser_out;
    pop_c      = 1'b0;
    case (state)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        ser_next  = 1'b1;
        if (!fifo_empty) begin
          pop_c      = 1'b1;
          shift_next = fifo_rd_data;
          state_next = START;
          ser_next   = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
          ser_next   = shift_q[0];
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_next  = '0;
          shift_next = shift_q >> 1;
          bit_next   = bit_idx + BIT_W'(1);
          ser_next   = shift_q[1];
          if (bit_idx == BIT_W'(UART_DATA_BITS - 1)) begin
            state_next = STOP;
            ser_next   = 1'b1;
          end
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_next = '0;
          if (!fifo_empty) begin
            pop_c      = 1'b1;
            shift_next = fifo_rd_data;
            state_next = START;
            ser_next   = 1'b0;
          end else begin
            state_next = IDLE;
            ser_next   = 1'b1;
          end
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = '0;
        bit_next   = '0;
        ser_next   = 1'b1;
      end
    endcase
  end

  // Busy looks ahead so it rises with the accepting edge and falls with the last stop clock.
  always_comb begin
    fifo_count_next = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
    busy_next       = (state_next != IDLE) || (fifo_count_next != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      ser_out  <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift_q  <= shift_next;
      ser_out  <= ser_next;
      tx_busy  <= busy_next;
    end
  end

endmodule
